// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter.
// FSM state encodings and width helpers.
package uart_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t SEND      = 2'd1;
  localparam state_t WAIT_ACK  = 2'd2;
  localparam state_t WAIT_DONE = 2'd3;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int burst_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Rotating priority encoder: first set request after the last pointer.
// Purely combinational.
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] pick,
  output logic         any
);

  logic found;
  int   idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!found && req[idx]) begin
        pick  = W'(idx);
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of one UART transmitter.
// Optional stalled-grant revocation: define ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int GW = grant_w(NUM_REQ);
  localparam int BW = burst_w(MAX_BURST);

  state_t            state;
  logic [GW-1:0]     last_ptr;
  logic [BW-1:0]     burst_cnt;
  logic              last_flag;
  logic [GW-1:0]     pick;
  logic              any;
  logic              cur_valid;
  logic              accept;
  logic              burst_done;
  logic              stall_hit;
  logic [DATA_W-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
    assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .N (NUM_REQ),
    .W (GW)
  ) u_pick (
    .req  (req_valid),
    .last (last_ptr),
    .pick (pick),
    .any  (any)
  );

  assign cur_valid  = req_valid[grant_id];
  assign accept     = (state == SEND) && cur_valid && !tx_busy;
  assign burst_done = last_flag || (burst_cnt == BW'(MAX_BURST));

  // Ready only while the line is free, so an in-flight frame is never cut.
  always_comb begin
    req_ready = '0;
    if (state == SEND && !tx_busy)
      req_ready[grant_id] = 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != SEND || cur_valid)
      stall_cnt <= '0;
    else
      stall_cnt <= stall_cnt + TW'(1);
  end

  assign stall_hit = (state == SEND) && !cur_valid &&
                     (stall_cnt == TW'(TIMEOUT - 1));
`else
  assign stall_hit = 1'b0 & (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_ptr    <= GW'(NUM_REQ - 1);
      burst_cnt   <= '0;
      last_flag   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            grant_valid <= 1'b1;
            grant_id    <= pick;
            burst_cnt   <= '0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (stall_hit) begin
            grant_valid <= 1'b0;
            last_ptr    <= grant_id;
            state       <= IDLE;
          end else if (accept) begin
            tx_data   <= req_bytes[grant_id];
            tx_start  <= 1'b1;
            burst_cnt <= burst_cnt + BW'(1);
            last_flag <= req_last[grant_id];
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (burst_done) begin
              grant_valid <= 1'b0;
              last_ptr    <= grant_id;
              state       <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a model transmitter
// and per-requester byte queues.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int BUSY = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic          grant_valid;
  logic [1:0]    grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (16),
    .TIMEOUT   (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]    qs [NR][$];
  logic [NR-1:0] took = '0;
  int            log_q [$];
  int            exp_q [$];
  int            busy_cnt = 0;
  int            overlap = 0;
  int            dgrant = 0;
  logic          prev_gv = 1'b0;
  logic [1:0]    prev_id = '0;

  typedef struct {
    logic [3:0] mask;
    int         n;
    logic [7:0] order;
  } rr_vec_t;

  rr_vec_t tbl [7];

  assign tx_busy = busy_cnt != 0;

  // model transmitter: busy for BUSY cycles after each start pulse
  always @(posedge clk) begin
    if (tx_start)
      busy_cnt <= BUSY;
    else if (busy_cnt != 0)
      busy_cnt <= busy_cnt - 1;
  end

  // requester driver and mid-cycle monitor
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (took[i] && qs[i].size() > 0)
        void'(qs[i].pop_front());
      req_valid[i] = qs[i].size() > 0;
      if (qs[i].size() > 0) begin
        req_data[i*DW +: DW] = qs[i][0][7:0];
        req_last[i]          = qs[i][0][8];
      end else begin
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
    if (tx_start) begin
      log_q.push_back(int'(grant_id) * 256 + int'(tx_data));
      if (tx_busy)
        overlap++;
    end
    if (grant_valid && prev_gv && grant_id != prev_id)
      dgrant++;
    prev_gv = grant_valid;
    prev_id = grant_id;
    #1;
    took = req_valid & req_ready;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] b, input logic l);
    qs[id].push_back({l, b});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NR; i++)
      qs[i].delete();
    took = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string nm);
    int  k;
    logic done;
    done = 1'b0;
    for (k = 0; k < 3000 && !done; k++) begin
      @(posedge clk); #1;
      done = !grant_valid && !tx_busy && took == '0;
      for (int i = 0; i < NR; i++)
        if (qs[i].size() > 0)
          done = 1'b0;
    end
    chk({nm, "_idle"}, int'(done), 1);
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", nm, i),
          (i < log_q.size()) ? log_q[i] : -1, exp_q[i]);
  endtask

  task automatic expect_b(input int id, input int b);
    exp_q.push_back(id * 256 + b);
  endtask

  initial begin
    int id;
    logic seen;

    tbl[0] = '{4'b0001, 1, 8'h00};
    tbl[1] = '{4'b0111, 3, 8'h09};
    tbl[2] = '{4'b1010, 2, 8'h0D};
    tbl[3] = '{4'b1111, 4, 8'hE4};
    tbl[4] = '{4'b1000, 1, 8'h03};
    tbl[5] = '{4'b0101, 2, 8'h08};
    tbl[6] = '{4'b1001, 2, 8'h03};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gv", int'(grant_valid), 0);
    chk("rst_gid", int'(grant_id), 0);
    chk("rst_start", int'(tx_start), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_ready", int'(req_ready), 0);
    rst = 1'b0;

    // single requester, latency, three bytes
    @(posedge clk); #1;
    log_q.delete();
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    @(negedge clk); #2;
    @(posedge clk); #1;
    chk("lat_gv", int'(grant_valid), 1);
    chk("lat_gid", int'(grant_id), 0);
    chk("lat_ready", int'(req_ready), 1);
    @(posedge clk); #1;
    chk("lat_start", int'(tx_start), 1);
    chk("lat_data", int'(tx_data), 8'h41);
    @(posedge clk); #1;
    chk("start_1cyc", int'(tx_start), 0);
    expect_b(0, 8'h41);
    expect_b(0, 8'h42);
    expect_b(0, 8'h43);
    wait_idle("single");
    check_log("single");
    chk("single_gv", int'(grant_valid), 0);

    // round-robin vector table, pointer carried across entries
    do_reset();
    for (int e = 0; e < 7; e++) begin
      @(posedge clk); #1;
      log_q.delete();
      exp_q.delete();
      for (int r = 0; r < NR; r++)
        if (tbl[e].mask[r])
          push(r, 8'(16 * r + e), 1'b1);
      for (int k = 0; k < tbl[e].n; k++) begin
        id = int'(tbl[e].order[2*k +: 2]);
        expect_b(id, 16 * id + e);
      end
      wait_idle($sformatf("rr%0d", e));
      check_log($sformatf("rr%0d", e));
    end

    // 2-byte packets from 0,1,2 then from 0,2
    do_reset();
    for (int r = 0; r < 3; r++) begin
      push(r, 8'(8'h20 + r), 1'b0);
      push(r, 8'(8'h30 + r), 1'b1);
      expect_b(r, 8'h20 + r);
      expect_b(r, 8'h30 + r);
    end
    wait_idle("pk3");
    push(0, 8'h50, 1'b0);
    push(0, 8'h51, 1'b1);
    push(2, 8'h52, 1'b0);
    push(2, 8'h53, 1'b1);
    expect_b(0, 8'h50);
    expect_b(0, 8'h51);
    expect_b(2, 8'h52);
    expect_b(2, 8'h53);
    wait_idle("pk2");
    check_log("pkts");

    // burst limit: 20 bytes from 1 with 3 waiting
    do_reset();
    for (int j = 0; j < 20; j++)
      push(1, 8'(8'h80 + j), j == 19);
    push(3, 8'hC0, 1'b0);
    push(3, 8'hC1, 1'b1);
    for (int j = 0; j < 16; j++)
      expect_b(1, 8'h80 + j);
    expect_b(3, 8'hC0);
    expect_b(3, 8'hC1);
    for (int j = 16; j < 20; j++)
      expect_b(1, 8'h80 + j);
    wait_idle("burst");
    check_log("burst");

    // reset while a frame is on the wire
    do_reset();
    push(0, 8'h55, 1'b1);
    push(2, 8'h77, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk); #1;
      seen = tx_busy;
    end
    chk("mid_busy_seen", int'(seen), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_gv", int'(grant_valid), 0);
    chk("mid_start", int'(tx_start), 0);
    chk("mid_data", int'(tx_data), 0);
    chk("mid_ready", int'(req_ready), 0);
    expect_b(0, 8'h55);
    expect_b(2, 8'h77);
    wait_idle("mid");
    check_log("mid");

    // stalled grant
    do_reset();
    push(0, 8'h61, 1'b0);
    push(1, 8'h71, 1'b1);
    repeat (300) @(posedge clk);
    #1;
`ifdef ARB_TIMEOUT_EN
    chk("to_len", log_q.size(), 2);
    chk("to_gv", int'(grant_valid), 0);
`else
    chk("to_len", log_q.size(), 1);
    chk("to_gv", int'(grant_valid), 1);
    chk("to_gid", int'(grant_id), 0);
`endif
    push(0, 8'h62, 1'b1);
    expect_b(0, 8'h61);
`ifdef ARB_TIMEOUT_EN
    expect_b(1, 8'h71);
    expect_b(0, 8'h62);
`else
    expect_b(0, 8'h62);
    expect_b(1, 8'h71);
`endif
    wait_idle("to");
    check_log("to");

    // back-to-back packets with a competitor
    do_reset();
    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b1);
    push(0, 8'hB1, 1'b0);
    push(0, 8'hB2, 1'b1);
    push(1, 8'hC7, 1'b1);
    expect_b(0, 8'hA1);
    expect_b(0, 8'hA2);
    expect_b(1, 8'hC7);
    expect_b(0, 8'hB1);
    expect_b(0, 8'hB2);
    wait_idle("b2b");
    check_log("b2b");

    chk("start_while_busy", overlap, 0);
    chk("double_grant", dgrant, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing the single UART transmitter between NUM_REQ byte-stream requesters (e.g. command echo, status reporter, debug dump).
- Grant is packet-locked: held until the requester's last byte or until MAX_BURST bytes, then rotated.
- Sits between the requester clients and the transmitter inside system, in the transmitter's clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width handed to the transmitter.
- MAX_BURST, 16, maximum bytes per grant before forced rotation (>=1).
- TIMEOUT, 255, idle cycles before a stalled grant is revoked (only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  byte available per requester
- req_data  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  current byte ends the packet
- req_ready  out  NUM_REQ  byte accepted this cycle (valid&ready)
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_data  out  DATA_W  byte for transmitter, stable from tx_start until tx_busy falls
- tx_busy  in  1  transmitter shifting a frame
- grant_valid  out  1  a requester currently holds the grant
- grant_id  out  clog2(NUM_REQ)  index of granted requester

Behaviour:
- Reset (sync, any state): state=IDLE, tx_start=0, tx_data=0, grant_valid=0, grant_id=0, req_ready=0, rr pointer last=NUM_REQ-1 (req 0 highest priority first), burst count=0.
- IDLE: if any req_valid, pick first set bit searching from (last+1) mod NUM_REQ; next cycle grant_valid=1, grant_id=pick, state=SEND, burst count=0. No valid -> stay.
- SEND: req_ready[grant_id] = !tx_busy (combinational); all other req_ready=0. On valid&ready: capture byte into tx_data, tx_start=1 next cycle for exactly one cycle, burst count+1, record last flag, state=WAIT_ACK.
- WAIT_ACK: wait for tx_busy=1 -> WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0. Then if recorded last or burst count==MAX_BURST: grant_valid=0, last=grant_id, state=IDLE; else state=SEND.
- Latency: req_valid in IDLE at cycle N -> grant at N+1 -> ready at N+1 (busy low) -> tx_start at N+2.
- Requester drops valid mid-packet: grant held, state stays SEND (no other requester served).
- Simultaneous requests: strictly round-robin; a released requester is lowest priority next arbitration.
- Release and re-grant never in same cycle: IDLE always occupies >=1 cycle between grants.
- Reset mid-frame while tx_busy=1: arbiter returns to IDLE; SEND waits for tx_busy=0 before accepting, so the in-flight frame is never corrupted.
- MAX_BURST=1: every byte rotates the grant.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: counter of consecutive SEND cycles with req_valid[grant_id]=0; at TIMEOUT, grant revoked (grant_valid=0, last=grant_id, IDLE); counter clears on any accept or grant change.
- Undefined: no counter; stalled requester holds grant indefinitely.

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, SEND, WAIT_ACK, WAIT_DONE), GRANT_W=clog2(NUM_REQ), BURST_W=clog2(MAX_BURST+1) constants.
- Sub-module rr_picker: combinational rotate-priority-encode (req vector, last pointer -> pick, any).

Test Plan:
- Single requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with model transmitter busy 10 cycles -> three tx_start pulses in order, grant_valid drops after 3rd tx_busy fall.
- Requesters 0,1,2 all valid with 2-byte packets -> service order 0,1,2; then only 0 and 2 request -> order 0,2 (pointer continues from 2 wraps to 0).
- Requester 1 sends 20-byte packet, requester 3 waiting, MAX_BURST=16 -> 16 bytes from 1, then 3's packet, then remaining 4 bytes of 1.
- Assert rst while tx_busy=1 with req 2 valid -> outputs reset next cycle; no tx_start until tx_busy falls.
- Requester 0 holds grant and drops valid 300 cycles, requester 1 valid -> with ARB_TIMEOUT_EN grant moves to 1 after 255 idle cycles; without it grant stays on 0.
- Back-to-back packets from requester 0 with requester 1 valid -> requester 1 granted between them (at least one IDLE cycle, no double grant).
